instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Instruction-side partner of the control unit. Owns the PC and fetches 32-bit ARM words
//  from instruction memory over a req/ack handshake. Presents each word as Instr with a
//  valid/ready handshake to decode. Accepts the PCSrc/branch-target redirect back from
//  decode, and flushes or drains any in-flight fetch.
// PARAMETERS
//  RESET_PC   32'h0000_0000   PC loaded on reset; bits [1:0] must be 0
//  ADDR_W     32              width of PC and memory address
// PORTS
//  clk            in   1       single clock; all state updates on rising edge
//  reset          in   1       asynchronous, active-high reset
//  imem_req       out  1       fetch request to instruction memory
//  imem_addr      out  ADDR_W  word-aligned fetch address, stable while imem_req=1
//  imem_ack       in   1       memory completes request; imem_rdata valid this cycle
//  imem_rdata     in   32      fetched instruction word
//  instr_valid    out  1       Instr/instr_pc hold a live instruction
//  instr_ready    in   1       decode accepts Instr this cycle
//  Instr          out  32      instruction word to control unit/datapath
//  instr_pc       out  ADDR_W  address of Instr
//  pc_plus8       out  ADDR_W  instr_pc+8 (ARM architectural PC read value)
//  PCSrc          in   1       redirect request from control unit
//  branch_target  in   ADDR_W  redirect address, sampled when PCSrc=1
// BEHAVIOUR
//  Reset: state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr_valid=0,
//   Instr=0, instr_pc=RESET_PC, pc_plus8=RESET_PC+8, redirect buffer cleared.
//   Reset is asynchronous: all outputs take these values immediately, including mid-fetch.
//   Memory must be reset together with this block; no ack is expected for pre-reset requests.
//  FSM states: IDLE, FETCH, DRAIN, HOLD.
//  IDLE: imem_req=0. Next cycle goes to FETCH. If PCSrc=1, pc<=branch_target first.
//  FETCH: imem_req=1, imem_addr=pc. req and addr stay stable until imem_ack.
//   ack & !PCSrc: Instr<=imem_rdata, instr_pc<=pc, pc<=pc+4, go to HOLD.
//   ack & PCSrc: discard rdata, pc<=branch_target, stay in FETCH. New address appears next cycle.
//   !ack & PCSrc: save target in redirect buffer, go to DRAIN.
//  DRAIN: imem_req=1 with the old address held; the handshake is never abandoned.
//   On ack: discard rdata, pc<=saved target, go to FETCH.
//   A further PCSrc in DRAIN overwrites the saved target (last one wins).
//  HOLD: instr_valid=1. Instr and instr_pc stay stable until accepted.
//   PCSrc=1 has priority over instr_ready: instr_valid<=0, pc<=branch_target, go to FETCH.
//   instr_ready & !PCSrc: instr_valid<=0, go to FETCH at the incremented pc.
//  instr_valid=1 only in HOLD. Minimum latency from a FETCH entry with 1-cycle ack to
//   instr_valid=1 is 1 cycle. Peak throughput is 1 instruction per 2 cycles; no prefetch.
//  Arithmetic: PC math is modulo 2^ADDR_W; 0xFFFF_FFFC+4 wraps to 0.
//   branch_target[1:0] is forced to 00. pc_plus8 is combinational from instr_pc.
//  imem_ack and imem_rdata are ignored when imem_req=0.
//  PCSrc is ignored only during reset.
// TESTING
//  T1 reset, RESET_PC=0, ack 1 cycle after req, rdata=E3A01005 -> imem_addr=0;
//     Instr=E3A01005, instr_pc=0, pc_plus8=8, valid=1; next fetch addr=4.
//  T2 instr_ready=0 for 3 cycles in HOLD -> Instr/instr_pc stable, imem_req=0;
//     ready=1 -> valid drops next cycle, fetch addr=4.
//  T3 PCSrc=1, target=0x43, together with instr_ready=1 in HOLD -> valid=0 next cycle,
//     next imem_addr=0x40, accepted word not consumed twice.
//  T4 ack latency 3, PCSrc=1 target=0x100 in cycle 1 of FETCH -> req held at old addr
//     until ack, rdata discarded (valid stays 0), then imem_addr=0x100.
//  T5 pc=0xFFFF_FFFC fetched and accepted -> next imem_addr=0x0000_0000.
//  T6 reset asserted mid-DRAIN -> same cycle: imem_req=0, instr_valid=0, addr=RESET_PC;
//     after release, first fetch is at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, fetches words over a req/ack handshake and hands
// them to decode with valid/ready. Redirects arriving mid-fetch wait in a buffer until the ack.
module instr_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       Instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [ADDR_W-1:0] pc_plus8,
  input  logic              PCSrc,
  input  logic [ADDR_W-1:0] branch_target
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HOLD} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] redir_q, redir_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;
  logic [ADDR_W-1:0] tgt;

  assign tgt = {branch_target[ADDR_W-1:2], 2'b00};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      redir_q <= '0;
      instr_q <= '0;
      ipc_q   <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      redir_q <= redir_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    redir_d = redir_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (PCSrc) pc_d = tgt;
      end
      FETCH: begin
        if (imem_ack && !PCSrc) begin
          instr_d = imem_rdata;
          ipc_d   = pc_q;
          pc_d    = pc_q + ADDR_W'(4);
          state_d = HOLD;
        end else if (imem_ack) begin
          pc_d = tgt;
        end else if (PCSrc) begin
          redir_d = tgt;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // The outstanding request must complete; a redirect on the ack cycle is the newest.
        if (PCSrc) redir_d = tgt;
        if (imem_ack) begin
          pc_d    = PCSrc ? tgt : redir_q;
          state_d = FETCH;
        end
      end
      HOLD: begin
        if (PCSrc) begin
          pc_d    = tgt;
          state_d = FETCH;
        end else if (instr_ready) begin
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    imem_req    = (state_q == FETCH) || (state_q == DRAIN);
    instr_valid = (state_q == HOLD);
    imem_addr   = pc_q;
    Instr       = instr_q;
    instr_pc    = ipc_q;
    pc_plus8    = ipc_q + ADDR_W'(8);
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus a randomized run scored against
// an address-sequence model of what decode should observe.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] Instr;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus8;
  logic        PCSrc = 1'b0;
  logic [31:0] branch_target = '0;

  int pass_cnt = 0;
  int total_cnt = 0;
  int lat = 0;
  bit rnd_mode = 1'b0;
  int cnt = 0;

  instr_fetch_unit dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .Instr(Instr), .instr_pc(instr_pc), .pc_plus8(pc_plus8),
    .PCSrc(PCSrc), .branch_target(branch_target)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0) ? 32'hE3A0_1005 : ((a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A);
  endfunction

  // Memory: acks after cnt wait cycles; drives junk on ack/rdata while idle in random mode.
  always @(negedge clk) begin
    if (reset) begin
      imem_ack = 1'b0;
      cnt = lat;
    end else if (!imem_req) begin
      imem_ack   = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b0;
      imem_rdata = $urandom;
      cnt = rnd_mode ? int'($urandom_range(0, 3)) : lat;
    end else if (cnt == 0) begin
      imem_ack   = 1'b1;
      imem_rdata = mem_word(imem_addr);
      cnt = rnd_mode ? int'($urandom_range(0, 3)) : lat;
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      cnt--;
    end
  end

  task automatic do_reset();
    PCSrc = 1'b0; instr_ready = 1'b0; reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 30 && !instr_valid; i++) @(negedge clk);
    total_cnt++;
    if (instr_valid !== 1'b1) $display("FAIL %s_timeout valid=%0b required=1", tag, instr_valid);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    total_cnt++; if (imem_req !== 1'b0) $display("FAIL rst_req got=%0b exp=0", imem_req); else pass_cnt++;
    total_cnt++; if (instr_valid !== 1'b0) $display("FAIL rst_valid got=%0b exp=0", instr_valid); else pass_cnt++;
    total_cnt++; if (imem_addr !== 32'h0) $display("FAIL rst_addr got=%h exp=0", imem_addr); else pass_cnt++;
    total_cnt++; if (Instr !== 32'h0) $display("FAIL rst_instr got=%h exp=0", Instr); else pass_cnt++;
    total_cnt++; if (instr_pc !== 32'h0) $display("FAIL rst_ipc got=%h exp=0", instr_pc); else pass_cnt++;
    total_cnt++; if (pc_plus8 !== 32'h8) $display("FAIL rst_pc8 got=%h exp=8", pc_plus8); else pass_cnt++;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_fetch_basic();
    lat = 0;
    for (int i = 0; i < 10 && !imem_req; i++) @(negedge clk);
    total_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("FAIL t1_req req=%0b addr=%h exp 1/0", imem_req, imem_addr); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (instr_valid !== 1'b1) $display("FAIL t1_latency valid=%0b exp=1", instr_valid); else pass_cnt++;
    total_cnt++; if (Instr !== 32'hE3A0_1005) $display("FAIL t1_instr got=%h exp=e3a01005", Instr); else pass_cnt++;
    total_cnt++; if (instr_pc !== 32'h0 || pc_plus8 !== 32'h8) $display("FAIL t1_pc ipc=%h pc8=%h exp 0/8", instr_pc, pc_plus8); else pass_cnt++;
  endtask

  task automatic test_hold_stall();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total_cnt++;
      if (instr_valid !== 1'b1 || imem_req !== 1'b0 || Instr !== 32'hE3A0_1005 || instr_pc !== 32'h0)
        $display("FAIL t2_stall%0d valid=%0b req=%0b instr=%h ipc=%h exp 1/0/e3a01005/0", i, instr_valid, imem_req, Instr, instr_pc);
      else pass_cnt++;
    end
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    total_cnt++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h4) $display("FAIL t2_accept valid=%0b req=%0b addr=%h exp 0/1/4", instr_valid, imem_req, imem_addr); else pass_cnt++;
  endtask

  task automatic test_redirect_hold();
    wait_valid("t3");
    total_cnt++; if (instr_pc !== 32'h4 || Instr !== mem_word(32'h4)) $display("FAIL t3_instr4 ipc=%h instr=%h exp 4/%h", instr_pc, Instr, mem_word(32'h4)); else pass_cnt++;
    PCSrc = 1'b1; branch_target = 32'h43; instr_ready = 1'b1;
    @(negedge clk);
    PCSrc = 1'b0; instr_ready = 1'b0;
    total_cnt++; if (instr_valid !== 1'b0 || imem_addr !== 32'h40) $display("FAIL t3_redir valid=%0b addr=%h exp 0/40", instr_valid, imem_addr); else pass_cnt++;
    wait_valid("t3b");
    total_cnt++; if (instr_pc !== 32'h40 || Instr !== mem_word(32'h40)) $display("FAIL t3_target ipc=%h exp 40", instr_pc); else pass_cnt++;
  endtask

  task automatic test_drain();
    lat = 2;
    @(negedge clk);
    @(negedge clk);
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    PCSrc = 1'b1; branch_target = 32'h100;
    total_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'h44) $display("FAIL t4_fetch req=%0b addr=%h exp 1/44", imem_req, imem_addr); else pass_cnt++;
    @(negedge clk);
    PCSrc = 1'b0;
    for (int i = 0; i < 2; i++) begin
      total_cnt++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h44 || instr_valid !== 1'b0)
        $display("FAIL t4_drain%0d req=%0b addr=%h valid=%0b exp 1/44/0", i, imem_req, imem_addr, instr_valid);
      else pass_cnt++;
      @(negedge clk);
    end
    total_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || instr_valid !== 1'b0) $display("FAIL t4_after req=%0b addr=%h valid=%0b exp 1/100/0", imem_req, imem_addr, instr_valid); else pass_cnt++;
    lat = 0;
    wait_valid("t4");
    total_cnt++; if (instr_pc !== 32'h100) $display("FAIL t4_target ipc=%h exp 100", instr_pc); else pass_cnt++;
  endtask

  task automatic test_wrap();
    PCSrc = 1'b1; branch_target = 32'hFFFF_FFFC;
    @(negedge clk);
    PCSrc = 1'b0;
    wait_valid("t5");
    total_cnt++; if (instr_pc !== 32'hFFFF_FFFC || pc_plus8 !== 32'h4) $display("FAIL t5_top ipc=%h pc8=%h exp fffffffc/4", instr_pc, pc_plus8); else pass_cnt++;
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    total_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("FAIL t5_wrap req=%0b addr=%h exp 1/0", imem_req, imem_addr); else pass_cnt++;
  endtask

  task automatic test_reset_in_drain();
    wait_valid("t6");
    lat = 3;
    repeat (2) @(negedge clk);
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    PCSrc = 1'b1; branch_target = 32'h200;
    @(negedge clk);
    PCSrc = 1'b0;
    total_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) $display("FAIL t6_drain req=%0b addr=%h exp 1/4", imem_req, imem_addr); else pass_cnt++;
    #2 reset = 1'b1;
    #1;
    total_cnt++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || imem_addr !== 32'h0 || instr_pc !== 32'h0)
      $display("FAIL t6_async req=%0b valid=%0b addr=%h ipc=%h exp 0/0/0/0", imem_req, instr_valid, imem_addr, instr_pc);
    else pass_cnt++;
    lat = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10 && !imem_req; i++) @(negedge clk);
    total_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("FAIL t6_refetch req=%0b addr=%h exp 1/0", imem_req, imem_addr); else pass_cnt++;
    wait_valid("t6b");
    total_cnt++; if (instr_pc !== 32'h0 || Instr !== 32'hE3A0_1005) $display("FAIL t6_first ipc=%h instr=%h exp 0/e3a01005", instr_pc, Instr); else pass_cnt++;
  endtask

  // Model: decode must see the address sequence RESET_PC, +4 per accept, jump on any redirect.
  task automatic test_random();
    logic [31:0] exp_pc, pinstr, pipc, paddr, t;
    bit pv, pend, src, rdy;
    int delivered;
    exp_pc = 32'h0; pv = 1'b0; pend = 1'b0; delivered = 0;
    rnd_mode = 1'b1;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      #1;
      if (instr_valid && !pv) begin
        delivered++;
        total_cnt++;
        if (instr_pc !== exp_pc || Instr !== mem_word(exp_pc) || pc_plus8 !== exp_pc + 32'd8)
          $display("FAIL rnd_deliver n=%0d ipc=%h instr=%h pc8=%h exp %h/%h/%h", n, instr_pc, Instr, pc_plus8, exp_pc, mem_word(exp_pc), exp_pc + 32'd8);
        else pass_cnt++;
      end
      if (instr_valid && pv) begin
        total_cnt++;
        if (Instr !== pinstr || instr_pc !== pipc) $display("FAIL rnd_stable n=%0d instr=%h ipc=%h exp %h/%h", n, Instr, instr_pc, pinstr, pipc);
        else pass_cnt++;
      end
      if (pend) begin
        total_cnt++;
        if (imem_req !== 1'b1 || imem_addr !== paddr) $display("FAIL rnd_hold n=%0d req=%0b addr=%h exp 1/%h", n, imem_req, imem_addr, paddr);
        else pass_cnt++;
      end
      src = ($urandom_range(0, 7) == 0);
      rdy = 1'($urandom_range(0, 1));
      t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      PCSrc = src; instr_ready = rdy; branch_target = t;
      if (src) exp_pc = t & 32'hFFFF_FFFC;
      else if (instr_valid && rdy) exp_pc = exp_pc + 32'd4;
      pv = instr_valid; pinstr = Instr; pipc = instr_pc;
      pend = imem_req && !imem_ack; paddr = imem_addr;
    end
    PCSrc = 1'b0; instr_ready = 1'b0; rnd_mode = 1'b0;
    total_cnt++; if (delivered < 50) $display("FAIL rnd_progress delivered=%0d required>=50", delivered); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_fetch_basic();
    test_hold_stall();
    test_redirect_hold();
    test_drain();
    test_wrap();
    test_reset_in_drain();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
